// File: rtl/am2901_useq_pkg.sv
// Shared types and microword layout for the Am2901 microprogram sequencer.
// Field offsets below the branch address are fixed; the rest depend on ADDR_W.
package am2901_useq_pkg;

    typedef enum logic [2:0] {
        NXT_CONT = 3'd0,
        NXT_JMP  = 3'd1,
        NXT_JZ   = 3'd2,
        NXT_JNC  = 3'd3,
        NXT_CALL = 3'd4,
        NXT_RET  = 3'd5,
        NXT_LOOP = 3'd6,
        NXT_HALT = 3'd7
    } next_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] CIN_ZERO  = 2'b00;
    localparam logic [1:0] CIN_ONE   = 2'b01;
    localparam logic [1:0] CIN_CARRY = 2'b10;
    localparam logic [1:0] CIN_EXT   = 2'b11;

    localparam logic [8:0] NOP_I = 9'h040;

    localparam int LD_CNT_BIT = 0;
    localparam int CIN_LSB    = 1;
    localparam int D_LSB      = 3;
    localparam int B_LSB      = 7;
    localparam int A_LSB      = 11;
    localparam int I_LSB      = 15;
    localparam int BR_LSB     = 24;

    function automatic int nxt_lsb(input int addr_w);
        return BR_LSB + addr_w;
    endfunction

endpackage

// File: rtl/am2901_useq_stack.sv
// Return-address LIFO for CALL/RET; the caller must not push when full or pop when empty.
module am2901_useq_stack #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              cp,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_m1;

    assign sp_m1 = sp - SP_W'(1);
    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign top   = mem[sp_m1[IDX_W-1:0]];

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    // Entries need no reset: resetting the pointer is what discards them.
    always_ff @(posedge cp) begin
        if (push && !full && !clear) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/am2901_useq.sv
// Microprogram sequencer driving one Am2901 slice, one microword per clock,
// with branch-on-flag, counted loops and a small subroutine stack.
module am2901_useq
    import am2901_useq_pkg::*;
#(
    parameter  int ADDR_W = 6,
    parameter  int DEPTH  = 4,
    localparam int UW     = 27 + ADDR_W
) (
    input  logic              cp,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              stack_err,
    output logic [ADDR_W-1:0] cs_addr,
    input  logic [UW-1:0]     cs_data,
    input  logic              z,
    input  logic              cout,
    input  logic              ext_cin,
    output logic [8:0]        am_i,
    output logic [3:0]        am_a,
    output logic [3:0]        am_b,
    output logic [3:0]        am_d,
    output logic              am_cin
);

    localparam int NXT_LSB = nxt_lsb(ADDR_W);

    state_t            state;
    logic [ADDR_W-1:0] upc;
    logic [3:0]        cnt;
    logic              carry_q;

    next_op_t          op;
    logic [ADDR_W-1:0] f_br;
    logic [8:0]        f_i;
    logic [3:0]        f_a;
    logic [3:0]        f_b;
    logic [3:0]        f_d;
    logic [1:0]        f_cin_sel;
    logic              f_ld_cnt;
    logic              run_cin;

    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] next_upc;
    logic [3:0]        cnt_next;
    logic              push_req;
    logic              pop_req;
    logic              err;
    logic              leave;

    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic              run;

    assign op        = next_op_t'(cs_data[NXT_LSB +: 3]);
    assign f_br      = cs_data[BR_LSB +: ADDR_W];
    assign f_i       = cs_data[I_LSB +: 9];
    assign f_a       = cs_data[A_LSB +: 4];
    assign f_b       = cs_data[B_LSB +: 4];
    assign f_d       = cs_data[D_LSB +: 4];
    assign f_cin_sel = cs_data[CIN_LSB +: 2];
    assign f_ld_cnt  = cs_data[LD_CNT_BIT];

    assign run     = (state == ST_RUN);
    assign cs_addr = upc;
    assign upc_inc = upc + ADDR_W'(1);

    always_comb begin
        run_cin = 1'b0;
        case (f_cin_sel)
            CIN_ZERO:  run_cin = 1'b0;
            CIN_ONE:   run_cin = 1'b1;
            CIN_CARRY: run_cin = carry_q;
            CIN_EXT:   run_cin = ext_cin;
            default:   run_cin = 1'b0;
        endcase
    end

    // Outside RUN the slice sees a no-write NOP so it never disturbs its registers.
    assign am_i   = run ? f_i     : NOP_I;
    assign am_a   = run ? f_a     : 4'd0;
    assign am_b   = run ? f_b     : 4'd0;
    assign am_d   = run ? f_d     : 4'd0;
    assign am_cin = run ? run_cin : 1'b0;

    always_comb begin
        next_upc = upc_inc;
        cnt_next = cnt;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err      = 1'b0;
        leave    = 1'b0;
        case (op)
            NXT_CONT: next_upc = upc_inc;
            NXT_JMP:  next_upc = f_br;
            NXT_JZ:   if (z) next_upc = f_br;
            NXT_JNC:  if (!cout) next_upc = f_br;
            NXT_CALL: begin
                if (stk_full) begin
                    err = 1'b1;
                end else begin
                    push_req = 1'b1;
                    next_upc = f_br;
                end
            end
            NXT_RET: begin
                if (stk_empty) begin
                    err = 1'b1;
                end else begin
                    pop_req  = 1'b1;
                    next_upc = stk_top;
                end
            end
            NXT_LOOP: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                    next_upc = f_br;
                end
            end
            NXT_HALT: leave = 1'b1;
            default:  next_upc = upc_inc;
        endcase
        if (err) leave = 1'b1;
        // A load in the same word wins over the decrement; the branch used the old count.
        if (f_ld_cnt) cnt_next = f_d;
    end

    am2901_useq_stack #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .cp       (cp),
        .rst_n    (rst_n),
        .clear    (!run && start),
        .push     (run && push_req),
        .pop      (run && pop_req),
        .push_data(upc_inc),
        .top      (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            upc       <= '0;
            cnt       <= 4'd0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        upc       <= start_addr;
                        carry_q   <= 1'b0;
                        stack_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_q <= cout;
                    cnt     <= cnt_next;
                    if (leave) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (err) stack_err <= 1'b1;
                    end else begin
                        upc <= next_upc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am2901_useq.sv
// Scoreboard bench for am2901_useq: stimulus queues the expected per-cycle
// address/opcode/carry trace, a negedge monitor pops and compares while busy.
module tb_am2901_useq;
    import am2901_useq_pkg::*;

    localparam int ADDR_W = 6;
    localparam int UW     = 27 + ADDR_W;

    logic              cp = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              busy;
    logic              done;
    logic              stack_err;
    logic [ADDR_W-1:0] cs_addr;
    logic [UW-1:0]     cs_data;
    logic              z;
    logic              cout;
    logic              ext_cin = 1'b0;
    logic [8:0]        am_i;
    logic [3:0]        am_a;
    logic [3:0]        am_b;
    logic [3:0]        am_d;
    logic              am_cin;

    logic [UW-1:0] cs_mem   [64];
    logic          z_map    [64];
    logic          cout_map [64];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [8:0]        i;
        logic              cin;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cycles = 0;

    am2901_useq #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .cp        (cp),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .busy      (busy),
        .done      (done),
        .stack_err (stack_err),
        .cs_addr   (cs_addr),
        .cs_data   (cs_data),
        .z         (z),
        .cout      (cout),
        .ext_cin   (ext_cin),
        .am_i      (am_i),
        .am_a      (am_a),
        .am_b      (am_b),
        .am_d      (am_d),
        .am_cin    (am_cin)
    );

    always #5 cp = ~cp;

    assign cs_data = cs_mem[cs_addr];
    assign z       = z_map[cs_addr];
    assign cout    = cout_map[cs_addr];

    // Every word carries opcode {100, own address} so the trace also checks am_i.
    function automatic logic [UW-1:0] mw(input logic [2:0] nxt, input logic [5:0] br,
                                         input logic [1:0] cin, input logic ld,
                                         input logic [3:0] d, input logic [5:0] at);
        return {nxt, br, {3'b100, at}, at[3:0], ~at[3:0], d, cin, ld};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_prog();
        for (int k = 0; k < 64; k++) begin
            cs_mem[k]   = mw(NXT_HALT, 6'd0, CIN_ZERO, 1'b0, 4'd0, 6'(k));
            z_map[k]    = 1'b0;
            cout_map[k] = 1'b0;
        end
    endtask

    task automatic expect_step(input logic [5:0] a, input logic c);
        exp_t e;
        e.addr = a;
        e.i    = {3'b100, a};
        e.cin  = c;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [5:0] sa);
        int n;
        done_cnt    = 0;
        busy_cycles = 0;
        @(negedge cp);
        start      = 1'b1;
        start_addr = sa;
        @(negedge cp);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge cp);
            n++;
        end
        check_output("run_timeout", 32'(busy), 32'd0);
        @(negedge cp);
        #1;
    endtask

    task automatic check_end(input string name, input int cycles, input logic err);
        check_output({name, "_busy_cycles"}, 32'(busy_cycles), 32'(cycles));
        check_output({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check_output({name, "_trace_left"}, 32'(exp_q.size()), 32'd0);
        check_output({name, "_stack_err"}, 32'(stack_err), 32'(err));
        check_output({name, "_idle_nop"}, 32'(am_i), 32'(NOP_I));
        exp_q.delete();
    endtask

    always @(negedge cp) begin
        exp_t e;
        if (busy) begin
            busy_cycles++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_step: got cs_addr %0d, expected no step", cs_addr);
            end else begin
                e = exp_q.pop_front();
                check_output("cs_addr", 32'(cs_addr), 32'(e.addr));
                check_output("am_i", 32'(am_i), 32'(e.i));
                check_output("am_cin", 32'(am_cin), 32'(e.cin));
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        clear_prog();
        #12;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_am_i", 32'(am_i), 32'(NOP_I));
        rst_n = 1'b1;
        @(negedge cp);
        #1;
        check_output("idle_busy", 32'(busy), 32'd0);
        check_output("idle_done", 32'(done), 32'd0);
        check_output("idle_am_i", 32'(am_i), 32'(NOP_I));
        check_output("idle_cs_addr", 32'(cs_addr), 32'd0);
        check_output("idle_stack_err", 32'(stack_err), 32'd0);

        // Straight-line run 5,6,7
        clear_prog();
        cs_mem[5] = mw(NXT_CONT, 6'd0, CIN_ZERO, 1'b0, 4'd0, 6'd5);
        cs_mem[6] = mw(NXT_CONT, 6'd0, CIN_ZERO, 1'b0, 4'd0, 6'd6);
        expect_step(6'd5, 1'b0);
        expect_step(6'd6, 1'b0);
        expect_step(6'd7, 1'b0);
        apply_stimulus(6'd5);
        check_end("seq", 3, 1'b0);

        // Counted loop: load 3, word 1 runs four times
        clear_prog();
        cs_mem[0] = mw(NXT_CONT, 6'd0, CIN_ZERO, 1'b1, 4'd3, 6'd0);
        cs_mem[1] = mw(NXT_LOOP, 6'd1, CIN_ZERO, 1'b0, 4'd0, 6'd1);
        expect_step(6'd0, 1'b0);
        for (int k = 0; k < 4; k++) expect_step(6'd1, 1'b0);
        expect_step(6'd2, 1'b0);
        apply_stimulus(6'd0);
        check_end("loop", 6, 1'b0);

        // Flag branches and carry-in selection
        clear_prog();
        ext_cin = 1'b1;
        cs_mem[10] = mw(NXT_JZ,   6'd20, CIN_ONE,   1'b0, 4'd0, 6'd10);
        z_map[10]  = 1'b1;
        cs_mem[20] = mw(NXT_JZ,   6'd30, CIN_ZERO,  1'b0, 4'd0, 6'd20);
        cs_mem[21] = mw(NXT_CONT, 6'd0,  CIN_ZERO,  1'b0, 4'd0, 6'd21);
        cout_map[21] = 1'b1;
        cs_mem[22] = mw(NXT_JNC,  6'd40, CIN_CARRY, 1'b0, 4'd0, 6'd22);
        cs_mem[40] = mw(NXT_CONT, 6'd0,  CIN_EXT,   1'b0, 4'd0, 6'd40);
        cs_mem[41] = mw(NXT_JNC,  6'd50, CIN_CARRY, 1'b0, 4'd0, 6'd41);
        cout_map[41] = 1'b1;
        cs_mem[42] = mw(NXT_HALT, 6'd0,  CIN_CARRY, 1'b0, 4'd0, 6'd42);
        expect_step(6'd10, 1'b1);
        expect_step(6'd20, 1'b0);
        expect_step(6'd21, 1'b0);
        expect_step(6'd22, 1'b1);
        expect_step(6'd40, 1'b1);
        expect_step(6'd41, 1'b0);
        expect_step(6'd42, 1'b1);
        apply_stimulus(6'd10);
        check_end("branch", 7, 1'b0);
        ext_cin = 1'b0;

        // Address wrap 63 -> 0
        clear_prog();
        cs_mem[63] = mw(NXT_CONT, 6'd0, CIN_ZERO, 1'b0, 4'd0, 6'd63);
        expect_step(6'd63, 1'b0);
        expect_step(6'd0, 1'b0);
        apply_stimulus(6'd63);
        check_end("wrap", 2, 1'b0);

        // Four nested calls and returns
        clear_prog();
        cs_mem[0]  = mw(NXT_CALL, 6'd10, CIN_ZERO, 1'b0, 4'd0, 6'd0);
        cs_mem[10] = mw(NXT_CALL, 6'd20, CIN_ZERO, 1'b0, 4'd0, 6'd10);
        cs_mem[20] = mw(NXT_CALL, 6'd30, CIN_ZERO, 1'b0, 4'd0, 6'd20);
        cs_mem[30] = mw(NXT_CALL, 6'd40, CIN_ZERO, 1'b0, 4'd0, 6'd30);
        cs_mem[40] = mw(NXT_RET,  6'd0,  CIN_ZERO, 1'b0, 4'd0, 6'd40);
        cs_mem[31] = mw(NXT_RET,  6'd0,  CIN_ZERO, 1'b0, 4'd0, 6'd31);
        cs_mem[21] = mw(NXT_RET,  6'd0,  CIN_ZERO, 1'b0, 4'd0, 6'd21);
        cs_mem[11] = mw(NXT_RET,  6'd0,  CIN_ZERO, 1'b0, 4'd0, 6'd11);
        expect_step(6'd0, 1'b0);
        expect_step(6'd10, 1'b0);
        expect_step(6'd20, 1'b0);
        expect_step(6'd30, 1'b0);
        expect_step(6'd40, 1'b0);
        expect_step(6'd31, 1'b0);
        expect_step(6'd21, 1'b0);
        expect_step(6'd11, 1'b0);
        expect_step(6'd1, 1'b0);
        apply_stimulus(6'd0);
        check_end("calls", 9, 1'b0);

        // Fifth call overflows
        cs_mem[40] = mw(NXT_CALL, 6'd50, CIN_ZERO, 1'b0, 4'd0, 6'd40);
        expect_step(6'd0, 1'b0);
        expect_step(6'd10, 1'b0);
        expect_step(6'd20, 1'b0);
        expect_step(6'd30, 1'b0);
        expect_step(6'd40, 1'b0);
        apply_stimulus(6'd0);
        check_end("overflow", 5, 1'b1);

        // Return with an empty stack
        cs_mem[5] = mw(NXT_RET, 6'd0, CIN_ZERO, 1'b0, 4'd0, 6'd5);
        expect_step(6'd5, 1'b0);
        apply_stimulus(6'd5);
        check_end("underflow", 1, 1'b1);

        // Reset in the middle of a long loop
        clear_prog();
        cs_mem[0] = mw(NXT_CONT, 6'd0, CIN_ZERO, 1'b1, 4'd15, 6'd0);
        cs_mem[1] = mw(NXT_LOOP, 6'd1, CIN_ZERO, 1'b0, 4'd0, 6'd1);
        expect_step(6'd0, 1'b0);
        for (int k = 0; k < 3; k++) expect_step(6'd1, 1'b0);
        done_cnt = 0;
        @(negedge cp);
        start      = 1'b1;
        start_addr = 6'd0;
        @(negedge cp);
        start = 1'b0;
        repeat (3) @(negedge cp);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_am_i", 32'(am_i), 32'(NOP_I));
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_cs_addr", 32'(cs_addr), 32'd0);
        check_output("midrst_trace_left", 32'(exp_q.size()), 32'd0);
        check_output("midrst_done", 32'(done_cnt), 32'd0);
        exp_q.delete();
        @(negedge cp);
        rst_n = 1'b1;

        clear_prog();
        cs_mem[5] = mw(NXT_CONT, 6'd0, CIN_ZERO, 1'b0, 4'd0, 6'd5);
        cs_mem[6] = mw(NXT_CONT, 6'd0, CIN_ZERO, 1'b0, 4'd0, 6'd6);
        expect_step(6'd5, 1'b0);
        expect_step(6'd6, 1'b0);
        expect_step(6'd7, 1'b0);
        apply_stimulus(6'd5);
        check_end("after_rst", 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
